// File: rtl/mem_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_master_pkg
// Shared definitions for the memory bus master:
//   - state_t      : FSM encoding (IDLE, ACCESS, RESP)
//   - BURST_LEN    : number of read beats in a burst
//   - BEAT_W       : width of the burst beat counter
//   - ADDR_W_DEF   : default memory word-address width
//   - DATA_W_DEF   : default bus data width
// ---------------------------------------------------------------------------
package mem_bus_master_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int BURST_LEN  = 4;
  localparam int BEAT_W     = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// ---------------------------------------------------------------------------
// mem_bus_master
// Bridges a simple CPU request/response port onto a chip-select memory with
// a shared tri-state data bus. The memory samples and updates on the falling
// clock edge; this block launches everything from rising-edge registers so
// the memory sees stable CS/WE/ADDR/data for the whole cycle.
//
// Handshake: a request transfers at a rising edge where req && req_ready.
// req_ready is high only in IDLE, so anything presented on req while it is
// low is ignored. Each completed beat produces a one-cycle rsp_valid pulse;
// rsp_valid has no back-pressure.
//
// Timing (cycle 0 = accept edge ends it):
//   cycle 1 : ACCESS, CS=1, memory acts on the falling edge
//   cycle 2 : RESP, rsp_valid=1 (read data captured at end of cycle 1)
//   cycle 3 : IDLE, earliest next accept
//
// Configuration macro: MEM_BUS_MASTER_BURST_EN
//   When defined, adds input req_burst. A read accepted with req_burst=1
//   stays in ACCESS for BURST_LEN cycles, stepping ADDR each cycle (wrapping
//   modulo 2^ADDR_W) and producing BURST_LEN consecutive rsp_valid pulses.
//   A write with req_burst=1 is a single write.
//
// Ports:
//   CLK        in   clock, rising-edge state changes
//   RST        in   asynchronous active-high reset
//   req        in   request valid
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address  [ADDR_W]
//   req_wdata  in   write data    [DATA_W]
//   req_burst  in   burst read request (only with MEM_BUS_MASTER_BURST_EN)
//   req_ready  out  request can be accepted this cycle
//   rsp_valid  out  one-cycle completion pulse per beat
//   rsp_rdata  out  read data, valid while rsp_valid [DATA_W]
//   CS         out  memory chip select
//   WE         out  memory write enable
//   ADDR       out  memory address [ADDR_W]
//   Mem_Bus    io   shared tri-state data bus [DATA_W]
//   fsm_state  out  current FSM state, for observation
// ---------------------------------------------------------------------------
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BUS_MASTER_BURST_EN
  input  logic              req_burst,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus,
  output state_t            fsm_state
);

  state_t              state_q;
  state_t              next_state;
  logic                accept;
  logic                burst_start;
  logic                cs_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BEAT_W-1:0]   beats_q;

`ifdef MEM_BUS_MASTER_BURST_EN
  // Bursts apply to reads only; a burst-flagged write is a single beat.
  assign burst_start = req_burst & ~req_we;
`else
  assign burst_start = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req & req_ready;

  // Next-state logic. beats_q counts the ACCESS cycles still to follow the
  // current one, so zero means this is the last beat.
  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (beats_q == '0) next_state = ST_RESP;
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      beats_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= next_state;
      // CS is registered from the next state so it is high exactly for the
      // ACCESS cycles and never follows req combinationally.
      cs_q    <= (next_state == ST_ACCESS);
      // Every ACCESS cycle completes one beat, reported in the cycle after.
      rsp_valid <= (state_q == ST_ACCESS);
      // The memory drives read data after the falling edge; capture it at
      // the rising edge that closes the ACCESS cycle. Writes leave the
      // previous read data in place.
      if ((state_q == ST_ACCESS) && !we_q) begin
        rsp_rdata <= Mem_Bus;
      end
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        beats_q <= burst_start ? BEAT_W'(BURST_LEN - 1) : '0;
      end else if ((state_q == ST_ACCESS) && (beats_q != '0)) begin
        // Address wraps naturally modulo 2^ADDR_W.
        addr_q  <= addr_q + ADDR_W'(1);
        beats_q <= beats_q - BEAT_W'(1);
      end
    end
  end

  assign CS        = cs_q;
  assign WE        = cs_q & we_q;
  assign ADDR      = addr_q;
  assign fsm_state = state_q;

  // The master owns the bus only while it is writing to a selected memory.
  assign Mem_Bus = (cs_q && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_master
// Bench for mem_bus_master with a 128x32 memory that acts on the falling
// clock edge. Expected read data is pushed into exp_q when a request is
// issued; a monitor pops and compares on every rsp_valid pulse. Directed
// checks cover reset values, CS/WE/ADDR timing, ignored requests,
// reset-abort behaviour on either side of the falling edge, back-to-back
// accept spacing and (with MEM_BUS_MASTER_BURST_EN) a wrapping burst read.
// ---------------------------------------------------------------------------
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
`ifdef MEM_BUS_MASTER_BURST_EN
  logic          req_burst = 1'b0;
`endif
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          CS;
  logic          WE;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] mem_bus;
  state_t        fsm_state;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_BUS_MASTER_BURST_EN
    .req_burst (req_burst),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .CS        (CS),
    .WE        (WE),
    .ADDR      (ADDR),
    .Mem_Bus   (mem_bus),
    .fsm_state (fsm_state)
  );

  // ---------------- memory model (negedge) ----------------
  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] mem_rdata;

  assign mem_bus = (CS && !WE) ? mem_rdata : {DW{1'bz}};

  always @(negedge CLK) begin
    if (CS && WE)  mem[ADDR] = mem_bus;
    if (CS && !WE) mem_rdata = mem[ADDR];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid with nothing pending, rdata 0x%08h (t=%0t)",
                 rsp_rdata, $time);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and returns 1 ns into cycle 1 with req dropped.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    @(posedge CLK); #1;
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles", n);
    end
    @(posedge CLK); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int acc_cyc [3];
  int accepts;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem_rdata = '0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_cs",    32'(CS),        32'd0);
    check("reset_we",    32'(WE),        32'd0);
    check("reset_addr",  32'(ADDR),      32'd0);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata,      32'd0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));

    // Write 0xDEADBEEF to 5; rsp_rdata keeps its reset value 0
    exp_q.push_back(32'h0000_0000);
    issue(1'b1, 7'd5, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("wr_c1_cs",   32'(CS),   32'd1);
    check("wr_c1_we",   32'(WE),   32'd1);
    check("wr_c1_addr", 32'(ADDR), 32'd5);
    #1 check("wr_commit", mem[5], 32'hDEAD_BEEF);
    @(negedge CLK);
    check("wr_c2_cs",    32'(CS),        32'd0);
    check("wr_c2_valid", 32'(rsp_valid), 32'd1);

    // Read 5, with a stray request presented while busy
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b0, 7'd5, 32'h0);
    req = 1'b1; req_we = 1'b1; req_addr = 7'd99; req_wdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    check("rd_c1_cs",    32'(CS),        32'd1);
    check("rd_c1_we",    32'(WE),        32'd0);
    check("rd_c1_addr",  32'(ADDR),      32'd5);
    check("rd_c1_ready", 32'(req_ready), 32'd0);
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK);
    check("rd_c2_cs",    32'(CS),        32'd0);
    check("rd_c2_we",    32'(WE),        32'd0);
    check("rd_c2_valid", 32'(rsp_valid), 32'd1);
    check("rd_c2_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("rd_c3_ready", 32'(req_ready), 32'd1);
    check("rd_c3_valid", 32'(rsp_valid), 32'd0);
    check("rd_c3_cs",    32'(CS),        32'd0);
    check("ignored_wr",  mem[99],        32'h0);

    // More patterns: preloaded read, write/read at top address
    mem[20] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    issue(1'b0, 7'd20, 32'h0);
    exp_q.push_back(32'h1234_5678);
    issue(1'b1, 7'd127, 32'h0000_A5A5);
    exp_q.push_back(32'h0000_A5A5);
    issue(1'b0, 7'd127, 32'h0);
    idle(3);
    check("drain_1", 32'(exp_q.size()), 32'd0);

    // Reset before the falling edge of a write to 9: nothing committed
    issue(1'b1, 7'd9, 32'h1111_2222);
    #1 RST = 1'b1;
    #1;
    check("abort_a_cs",    32'(CS),        32'd0);
    check("abort_a_we",    32'(WE),        32'd0);
    check("abort_a_valid", 32'(rsp_valid), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK); #1;
    check("abort_a_mem", mem[9], 32'h0);
    exp_q.push_back(32'h0000_0000);
    issue(1'b0, 7'd9, 32'h0);

    // Reset after the falling edge of a write to 10: already committed
    issue(1'b1, 7'd10, 32'h3333_4444);
    #6;
    check("abort_b_mem", mem[10], 32'h3333_4444);
    RST = 1'b1;
    #1 check("abort_b_cs", 32'(CS), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    exp_q.push_back(32'h3333_4444);
    issue(1'b0, 7'd10, 32'h0);
    idle(3);
    check("drain_2", 32'(exp_q.size()), 32'd0);

    // req held high: accepts 3 cycles apart, one response each
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hDEAD_BEEF);
    req = 1'b1; req_we = 1'b0; req_addr = 7'd5;
    accepts = 0;
    for (int i = 0; i < 30 && accepts < 3; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        acc_cyc[accepts] = cyc;
        accepts++;
      end
    end
    @(posedge CLK); #1 req = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd3);
    check("hold_gap_1",   32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("hold_gap_2",   32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    idle(4);
    check("drain_3", 32'(exp_q.size()), 32'd0);

`ifdef MEM_BUS_MASTER_BURST_EN
    // Burst read from 126 wraps through 127, 0, 1
    mem[126] = 32'hA; mem[127] = 32'hB; mem[0] = 32'hC; mem[1] = 32'hD;
    exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    exp_q.push_back(32'hC); exp_q.push_back(32'hD);
    req_burst = 1'b1;
    issue(1'b0, 7'd126, 32'h0);
    req_burst = 1'b0;
    @(negedge CLK);
    check("burst_c1_addr", 32'(ADDR), 32'd126);
    check("burst_c1_cs",   32'(CS),   32'd1);
    @(negedge CLK);
    check("burst_c2_addr",  32'(ADDR),      32'd127);
    check("burst_c2_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK);
    check("burst_c3_addr",  32'(ADDR),      32'd0);
    check("burst_c3_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK);
    check("burst_c4_addr",  32'(ADDR),      32'd1);
    check("burst_c4_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK);
    check("burst_c5_cs",    32'(CS),        32'd0);
    check("burst_c5_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK);
    check("burst_c6_valid", 32'(rsp_valid), 32'd0);

    // Burst flag on a write gives a single write
    exp_q.push_back(32'hD);
    req_burst = 1'b1;
    issue(1'b1, 7'd126, 32'h77);
    req_burst = 1'b0;
    idle(4);
    check("burst_wr_126", mem[126], 32'h77);
    check("burst_wr_127", mem[127], 32'hB);
    check("drain_4", 32'(exp_q.size()), 32'd0);
`endif

    idle(2);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  request valid from CPU side.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  ADDR_W  target word address.
REQ-008 SHALL have port req_wdata  input  DATA_W  write data.
REQ-009 SHALL have port req_ready  output  1  request accepted when req && req_ready at a rising edge.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse per beat.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, valid while rsp_valid.
REQ-012 SHALL have ports CS, WE (output, 1) and ADDR (output, ADDR_W): memory chip select, write enable, address.
REQ-013 SHALL have port Mem_Bus  inout  DATA_W  shared tri-state data bus.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-015 On accept in IDLE, SHALL register addr/we/wdata and enter ACCESS next cycle (cycle 1).
REQ-016 In ACCESS, CS = 1, WE = registered we, and ADDR = registered addr, all driven from registers (no combinational path from req).
REQ-017 SHALL drive Mem_Bus with write data only when CS = 1 and WE = 1; otherwise Mem_Bus SHALL be high-Z.
REQ-018 Read: SHALL capture Mem_Bus into rsp_rdata at the rising edge ending cycle 1 (memory updates on the falling edge mid-cycle) and assert rsp_valid in cycle 2.
REQ-019 Write: memory commits on the falling edge in cycle 1; rsp_valid SHALL pulse in cycle 2 and rsp_rdata SHALL hold its previous value.
REQ-020 RESP SHALL last exactly one cycle with CS = 0 and WE = 0, then return to IDLE; a new request is accepted earliest in cycle 3.
REQ-021 req deasserted or changed while req_ready = 0 SHALL be ignored.
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_W.

Reset
REQ-023 RST SHALL immediately force state IDLE, CS = 0, WE = 0, ADDR = 0, rsp_valid = 0, rsp_rdata = 0, Mem_Bus high-Z, req_ready = 1 after release.
REQ-024 RST asserted mid-ACCESS SHALL abort the access with no rsp_valid pulse.

Configuration
REQ-025 Macro MEM_BUS_MASTER_BURST_EN: when defined, SHALL add input req_burst (1 bit); a read accepted with req_burst = 1 SHALL stay in ACCESS 4 cycles, incrementing ADDR each cycle (wrapping 127 -> 0), producing 4 consecutive rsp_valid pulses in cycles 2-5.
REQ-026 With MEM_BUS_MASTER_BURST_EN defined, req_burst with req_we = 1 SHALL perform a single write.
REQ-027 Without the macro, req_burst SHALL not exist and all accesses SHALL be single-beat.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE, ACCESS, RESP), the burst length constant (4) and the default widths.
REQ-029 SHALL be a single module with no sub-modules; the tri-state driver SHALL be one continuous assignment.

Verification
REQ-030 Bench SHALL connect the block to the existing 128x32 negedge memory model.
REQ-031 Write 0xDEADBEEF to addr 5, then read addr 5 -> rsp_rdata = 0xDEADBEEF in cycle 2 after accept.
REQ-032 Read with CS timing checked: CS = 1 for exactly one cycle, and Mem_Bus is never driven by the master while WE = 0 (no X on bus).
REQ-033 Assert RST in cycle 1 of a write to addr 9 (old value 0) -> CS = 0 at once, no rsp_valid, and a subsequent read of addr 9 returns 0 or the new data, with the expected value following the falling-edge position.
REQ-034 With req held high continuously -> accepts spaced exactly 3 cycles apart, one rsp_valid per accept.
REQ-035 BURST_EN: addresses 126, 127, 0, 1 preloaded with 0xA, 0xB, 0xC, 0xD, burst read from 126 -> rsp_rdata 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles.
